// File: rtl/odd_counter.sv
// Free-running odd-number counter: 1, 3, 5, ... 2^WIDTH-1, then wraps to 1.
// Only the upper WIDTH-1 bits are stored; bit 0 is constant 1, so cnt can never be even.
module odd_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-2:0] half_reg;
  logic [WIDTH-2:0] half_next;

  // Adding 1 to the upper bits is the same as adding 2 to cnt, modulo 2^WIDTH
  assign half_next = half_reg + (WIDTH-1)'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_reg <= '0;
    end else begin
      half_reg <= half_next;
    end
  end

  assign cnt = {half_reg, 1'b1};

endmodule

// File: tb/tb_odd_counter.sv
// Directed and random-reset bench for odd_counter with an expected-value queue.
module tb_odd_counter;

  logic       clk;
  logic       reset;
  logic [7:0] cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] model;
  logic [7:0] exp_q[$];
  bit         seen[256];
  int         distinct;

  odd_counter #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: model the edge, queue the expectation, compare on the falling edge.
  task automatic step(input string tag);
    logic [7:0] exp;
    model = reset ? model + 8'd2 : 8'd1;
    exp_q.push_back(model);
    @(posedge clk);
    @(negedge clk);
    exp = exp_q.pop_front();
    $display("step %s reset=%0b cnt=%0d expected=%0d", tag, reset, cnt, exp);
    check(tag, cnt, exp);
    check({tag, "_lsb"}, {7'd0, cnt[0]}, 8'd1);
  endtask

  initial begin
    reset = 1'b0;
    model = 8'd1;
    #1;
    check("reset_before_edge", cnt, 8'd1);

    // Reset hold across two edges
    for (int i = 0; i < 2; i++) step("reset_hold");

    // Release and first 10 edges: 3..21
    reset = 1'b1;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step("seq");
      seen[cnt] = 1'b1;
    end
    check("seq_edge10", cnt, 8'd21);

    // Continue to edge 128, watching the wrap points
    for (int i = 11; i <= 128; i++) begin
      step("period");
      seen[cnt] = 1'b1;
      if (i == 126) check("edge126", cnt, 8'd253);
      if (i == 127) check("edge127", cnt, 8'd255);
      if (i == 128) check("edge128_wrap", cnt, 8'd1);
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check("distinct_odd_values", 8'(distinct), 8'd128);

    // Second lap
    for (int i = 0; i < 5; i++) step("lap2");
    check("lap2_end", cnt, 8'd11);

    // Run up to 8'h57 with a bounded loop
    for (int i = 0; i < 200 && model != 8'h57; i++) step("to_57");
    check("reached_57", cnt, 8'h57);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    model = 8'd1;
    #1;
    check("async_reset_immediate", cnt, 8'd1);
    @(negedge clk);
    check("async_reset_held", cnt, 8'd1);
    reset = 1'b1;
    step("after_async_release");
    check("after_async_value", cnt, 8'd3);

    // Random reset run
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 9) != 0);
      if (!reset) begin
        model = 8'd1;
        #1;
        check("rand_async", cnt, 8'd1);
      end
      step("rand");
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_residue observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
